// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//   Decode-stage hazard detection and forwarding selection for a MIPS-style
//   in-order pipeline. Each instruction in decode is classified by when it
//   needs its sources (Tuse) and when its result becomes available (Tnew).
//   A small scoreboard holds {dest, tnew} for the instructions already past
//   decode, so decode can either stall or pick the nearest forwarding stage.
//
// Parameters
//   STAGES : number of post-decode stages tracked (E=1, M=2, W=3, ...), 2..6
//   SELW   : forward-select width, at least clog2(STAGES+1)
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-high; clears scoreboard and counter
//   en         : pipeline advance enable; state is frozen while low
//   instr_d    : instruction currently in decode
//   stall      : hold F/D and inject a bubble into E (combinational)
//   fwd_rs_sel : rs source, 0 = register file, k = stage k
//   fwd_rt_sel : rt source, same encoding
//   stall_cnt  : count of advancing cycles spent stalled (wraps)
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int STAGES = 3,
  parameter int SELW   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [31:0]     instr_d,
  output logic            stall,
  output logic [SELW-1:0] fwd_rs_sel,
  output logic [SELW-1:0] fwd_rt_sel,
  output logic [31:0]     stall_cnt
);

  // Tuse value meaning "source not read"
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Scoreboard: entry k is the instruction k stages past decode
  logic [4:0]  sb_dest_q [1:STAGES];
  logic [4:0]  sb_dest_d [1:STAGES];
  logic [1:0]  sb_tnew_q [1:STAGES];
  logic [1:0]  sb_tnew_d [1:STAGES];
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Decode fields
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;
  logic [4:0] dest;
  logic [1:0] tnew;
  logic       unused_shamt;

  assign op           = instr_d[31:26];
  assign rs           = instr_d[25:21];
  assign rt           = instr_d[20:16];
  assign rd           = instr_d[15:11];
  assign funct        = instr_d[5:0];
  assign unused_shamt = ^instr_d[10:6];

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  always_comb begin
    tuse_rs = TUSE_NONE;
    tuse_rt = TUSE_NONE;
    dest    = 5'd0;
    tnew    = 2'd0;
    unique case (op)
      OP_RTYPE: begin
        if (funct == FN_ADDU || funct == FN_SUBU) begin
          tuse_rs = 2'd1;
          tuse_rt = 2'd1;
          dest    = rd;
          tnew    = 2'd1;
        end else if (funct == FN_JR) begin
          tuse_rs = 2'd0;
        end
      end
      OP_ORI: begin
        tuse_rs = 2'd1;
        dest    = rt;
        tnew    = 2'd1;
      end
      OP_LUI: begin
        dest = rt;
        tnew = 2'd1;
      end
      OP_LW: begin
        tuse_rs = 2'd1;
        dest    = rt;
        tnew    = 2'd2;
      end
      OP_SW: begin
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      OP_BEQ, OP_BNE: begin
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      OP_JAL: begin
        dest = 5'd31;
        tnew = 2'd0;
      end
      OP_J: begin
        dest = 5'd0;
      end
      default: begin
        dest = 5'd0;
      end
    endcase
  end

  // Per-source nearest-match search. Index 0 = rs, 1 = rt.
  // Only scoreboard entries are searched, so an instruction that reads and
  // writes the same register never sees itself.
  logic [4:0]      src        [2];
  logic [1:0]      src_tuse   [2];
  logic            match_vld  [2];
  logic [SELW-1:0] match_k    [2];
  logic [1:0]      match_tnew [2];
  logic            src_stall  [2];
  logic [SELW-1:0] src_sel    [2];

  assign src[0]      = rs;
  assign src[1]      = rt;
  assign src_tuse[0] = tuse_rs;
  assign src_tuse[1] = tuse_rt;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      match_vld[s]  = 1'b0;
      match_k[s]    = '0;
      match_tnew[s] = 2'd0;
      // Walk oldest to youngest so the youngest (smallest k) match wins
      for (int k = STAGES; k >= 1; k--) begin
        if (src_tuse[s] != TUSE_NONE && src[s] != 5'd0 && sb_dest_q[k] == src[s]) begin
          match_vld[s]  = 1'b1;
          match_k[s]    = SELW'(k);
          match_tnew[s] = sb_tnew_q[k];
        end
      end
      src_stall[s] = match_vld[s] && (match_tnew[s] > src_tuse[s]);
      src_sel[s]   = (match_vld[s] && match_tnew[s] == 2'd0) ? match_k[s] : '0;
    end
  end

  assign stall      = src_stall[0] | src_stall[1];
  assign fwd_rs_sel = src_sel[0];
  assign fwd_rt_sel = src_sel[1];
  assign stall_cnt  = stall_cnt_q;

  // Next-state: shift the scoreboard one stage, aging tnew; a stall injects
  // a bubble into E instead of the held decode instruction.
  always_comb begin
    sb_dest_d   = sb_dest_q;
    sb_tnew_d   = sb_tnew_q;
    stall_cnt_d = stall_cnt_q;
    if (en) begin
      for (int k = STAGES; k >= 2; k--) begin
        sb_dest_d[k] = sb_dest_q[k-1];
        sb_tnew_d[k] = sat_dec(sb_tnew_q[k-1]);
      end
      sb_dest_d[1] = stall ? 5'd0 : dest;
      sb_tnew_d[1] = stall ? 2'd0 : tnew;
      if (stall) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) begin
        sb_dest_q[k] <= 5'd0;
        sb_tnew_q[k] <= 2'd0;
      end
      stall_cnt_q <= 32'd0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        sb_dest_q[k] <= sb_dest_d[k];
        sb_tnew_q[k] <= sb_tnew_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//   Directed bench for hazard_unit. A behavioural model records, for each
//   pipeline slot, the instruction's destination and its original Tnew; the
//   remaining latency at slot k is derived from its age. A compare process
//   checks every output against the model at each falling edge, and the
//   directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int STAGES = 3;
  localparam int SELW   = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic [31:0]     instr_d;
  logic            stall;
  logic [SELW-1:0] fwd_rs_sel;
  logic [SELW-1:0] fwd_rt_sel;
  logic [31:0]     stall_cnt;

  hazard_unit #(.STAGES(STAGES), .SELW(SELW)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .instr_d    (instr_d),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: slot k holds dest and the Tnew it had on entering E
  int          m_dest [1:STAGES];
  int          m_t0   [1:STAGES];
  logic [31:0] m_cnt;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input int s, input int t, input int d, input int f);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'h00, 6'(f)};
  endfunction
  function automatic logic [31:0] enc_i(input int op, input int s, input int t);
    return {6'(op), 5'(s), 5'(t), 16'h0004};
  endfunction
  function automatic logic [31:0] ADDU(input int d, input int s, input int t); return enc_r(s, t, d, 'h21); endfunction
  function automatic logic [31:0] SUBU(input int d, input int s, input int t); return enc_r(s, t, d, 'h23); endfunction
  function automatic logic [31:0] JR(input int s);                            return enc_r(s, 0, 0, 'h08); endfunction
  function automatic logic [31:0] ORI(input int t, input int s);              return enc_i('h0D, s, t); endfunction
  function automatic logic [31:0] LUI(input int t);                           return enc_i('h0F, 0, t); endfunction
  function automatic logic [31:0] LW(input int t, input int s);               return enc_i('h23, s, t); endfunction
  function automatic logic [31:0] SW(input int t, input int s);               return enc_i('h2B, s, t); endfunction
  function automatic logic [31:0] BEQ(input int s, input int t);              return enc_i('h04, s, t); endfunction
  function automatic logic [31:0] BNE(input int s, input int t);              return enc_i('h05, s, t); endfunction
  function automatic logic [31:0] JAL();                                      return {6'h03, 26'h0000100}; endfunction
  function automatic logic [31:0] J();                                        return {6'h02, 26'h0000100}; endfunction

  // ---------------- model ----------------
  // Table lookup: Tuse 3 means the source is not read; dest 0 means none.
  task automatic dec(input logic [31:0] ins, output int tu_rs, output int tu_rt,
                     output int dd, output int tn);
    int op;
    int fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    tu_rs = 3; tu_rt = 3; dd = 0; tn = 0;
    if (op == 0 && (fn == 'h21 || fn == 'h23)) begin
      tu_rs = 1; tu_rt = 1; dd = int'(ins[15:11]); tn = 1;
    end else if (op == 0 && fn == 'h08) tu_rs = 0;
    else if (op == 'h0D) begin tu_rs = 1; dd = int'(ins[20:16]); tn = 1; end
    else if (op == 'h0F) begin dd = int'(ins[20:16]); tn = 1; end
    else if (op == 'h23) begin tu_rs = 1; dd = int'(ins[20:16]); tn = 2; end
    else if (op == 'h2B) begin tu_rs = 1; tu_rt = 2; end
    else if (op == 'h04 || op == 'h05) begin tu_rs = 0; tu_rt = 0; end
    else if (op == 'h03) begin dd = 31; tn = 0; end
  endtask

  task automatic model_eval(input logic [31:0] ins, output bit st, output int sel_rs, output int sel_rt);
    int tu[2];
    int r[2];
    int sel[2];
    int dd, tn, rem;
    bit found;
    dec(ins, tu[0], tu[1], dd, tn);
    r[0] = int'(ins[25:21]);
    r[1] = int'(ins[20:16]);
    st = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel[s] = 0;
      found  = 1'b0;
      if (tu[s] != 3 && r[s] != 0) begin
        for (int k = 1; k <= STAGES; k++) begin
          if (!found && m_dest[k] == r[s]) begin
            found = 1'b1;
            rem   = m_t0[k] - (k - 1);
            if (rem < 0) rem = 0;
            if (rem > tu[s]) st = 1'b1;
            else if (rem == 0) sel[s] = k;
          end
        end
      end
    end
    sel_rs = sel[0];
    sel_rt = sel[1];
  endtask

  task automatic model_step();
    bit st;
    int a, b, t1, t2, dd, tn;
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) begin m_dest[k] = 0; m_t0[k] = 0; end
      m_cnt = 32'd0;
    end else if (en) begin
      model_eval(instr_d, st, a, b);
      dec(instr_d, t1, t2, dd, tn);
      for (int k = STAGES; k >= 2; k--) begin
        m_dest[k] = m_dest[k-1];
        m_t0[k]   = m_t0[k-1];
      end
      m_dest[1] = st ? 0 : dd;
      m_t0[1]   = st ? 0 : tn;
      if (st) m_cnt = m_cnt + 32'd1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit e_st;
    int e_rs, e_rt;
    if (chk_en) begin
      model_eval(instr_d, e_st, e_rs, e_rt);
      check("model_stall", 32'(stall), 32'(e_st));
      check("model_rs_sel", 32'(fwd_rs_sel), 32'(e_rs));
      check("model_rt_sel", 32'(fwd_rt_sel), 32'(e_rt));
      check("model_stall_cnt", stall_cnt, m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [31:0] ins);
    instr_d = ins;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic expect_out(input string nm, input bit st, input int rs_sel, input int rt_sel);
    check({nm, "_stall"}, 32'(stall), 32'(st));
    check({nm, "_rs"}, 32'(fwd_rs_sel), 32'(rs_sel));
    check({nm, "_rt"}, 32'(fwd_rt_sel), 32'(rt_sel));
  endtask

  task automatic flush();
    drive(32'h0);
    repeat (STAGES) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] tbl [12];

  initial begin
    bit st;
    int a, b, idx, guard;
    reset   = 1'b1;
    en      = 1'b0;
    instr_d = 32'h0;
    tick();
    tick();
    reset  = 1'b0;
    en     = 1'b1;
    chk_en = 1'b1;

    // Reset state: nothing in flight, any decode instruction is clear
    drive(BEQ(1, 2));
    expect_out("reset", 1'b0, 0, 0);
    check("reset_cnt", stall_cnt, 32'd0);

    // lw $1 then addu $3,$1,$4: one stall, then no forwarding (tnew 1)
    drive(LW(1, 2));  tick();
    drive(ADDU(3, 1, 4));
    expect_out("lwuse_c1", 1'b1, 0, 0);
    tick();
    expect_out("lwuse_c2", 1'b0, 0, 0);
    tick();
    check("lwuse_cnt", stall_cnt, 32'd1);
    flush();

    // addu $5 then beq $5,$0: one stall, then forward from M
    drive(ADDU(5, 6, 7)); tick();
    drive(BEQ(5, 0));
    expect_out("beq_c1", 1'b1, 0, 0);
    tick();
    expect_out("beq_c2", 1'b0, 2, 0);
    tick();
    check("beq_cnt", stall_cnt, 32'd2);
    flush();

    // jal then jr $31: forward from E with no stall
    drive(JAL()); tick();
    drive(JR(31));
    expect_out("jr", 1'b0, 1, 0);
    tick();
    flush();

    // lui $0 then addu $3,$0,$0: $0 never forwards
    drive(LUI(0)); tick();
    drive(ADDU(3, 0, 0));
    expect_out("r0", 1'b0, 0, 0);
    tick();
    flush();

    // lw $1 then sw $1: store data needed late, no stall
    drive(LW(1, 2)); tick();
    drive(SW(1, 2));
    expect_out("sw", 1'b0, 0, 0);
    tick();
    flush();

    // ori $1, lw $1, beq $1,$1: nearest (lw) governs, two stalls
    do_reset();
    drive(ORI(1, 2)); tick();
    drive(LW(1, 2));
    expect_out("near_lw", 1'b0, 0, 0);
    tick();
    drive(BEQ(1, 1));
    expect_out("near_c1", 1'b1, 0, 0);
    tick();
    expect_out("near_c2", 1'b1, 0, 0);
    tick();
    expect_out("near_c3", 1'b0, 3, 3);
    tick();
    check("near_cnt", stall_cnt, 32'd2);
    flush();

    // reset in the middle of a lw-use stall
    do_reset();
    drive(LW(1, 2)); tick();
    drive(ADDU(3, 1, 4));
    expect_out("rst_mid_pre", 1'b1, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    expect_out("rst_mid_post", 1'b0, 0, 0);
    check("rst_mid_cnt", stall_cnt, 32'd0);
    flush();

    // en=0 for three cycles during a stall: everything frozen
    drive(LW(1, 2)); tick();
    drive(ADDU(3, 1, 4));
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("hold", 1'b1, 0, 0);
      check("hold_cnt", stall_cnt, 32'd0);
    end
    en = 1'b1;
    tick();
    expect_out("resume", 1'b0, 0, 0);
    check("resume_cnt", stall_cnt, 32'd1);
    flush();

    // Mixed stream, checked by the model; stalled instructions are held
    tbl[0]  = ADDU(1, 2, 3);
    tbl[1]  = SUBU(2, 1, 1);
    tbl[2]  = LW(3, 1);
    tbl[3]  = SW(3, 2);
    tbl[4]  = ORI(4, 3);
    tbl[5]  = BNE(4, 3);
    tbl[6]  = LUI(5);
    tbl[7]  = JR(5);
    tbl[8]  = J();
    tbl[9]  = 32'h0;
    tbl[10] = ADDU(6, 5, 4);
    tbl[11] = ADDU(6, 6, 6);
    idx   = 0;
    guard = 0;
    while (idx < 12 && guard < 100) begin
      drive(tbl[idx]);
      model_eval(instr_d, st, a, b);
      tick();
      if (!st) idx++;
      guard++;
    end
    check("stream_done", 32'(idx), 32'd12);
    flush();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter STAGES, default 3, giving the number of post-decode stages tracked (E=1, M=2, W=3, ...), legal range 2..6.
REQ-002 SHALL have parameter SELW, default 3, giving the forward-select width; SELW >= clog2(STAGES+1).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: pipeline advance enable.
REQ-006 SHALL have port instr_d, input, 32 bits: the instruction currently in decode.
REQ-007 SHALL have port stall, output, 1 bit: hold F/D and bubble E.
REQ-008 SHALL have port fwd_rs_sel, output, SELW bits: decode-stage rs source; 0 = register file, k = stage k.
REQ-009 SHALL have port fwd_rt_sel, output, SELW bits: same as fwd_rt_sel's rs counterpart, for rt.
REQ-010 SHALL have port stall_cnt, output, 32 bits: number of cycles with stall=1 and en=1.

Function
REQ-011 SHALL decode instr_d combinationally into Tuse_rs, Tuse_rt, dest, and Tnew.
- Sources with Tuse 3 are marked unused.
- Tnew is a 2-bit value measured at entry to E.
REQ-012 SHALL decode with this table (Tuse_rs / Tuse_rt / dest / Tnew):
- addu, subu: 1 / 1 / rd / 1.
- ori: 1 / - / rt / 1.
- lui: - / - / rt / 1.
- lw: 1 / - / rt / 2.
- sw: 1 / 2 / none / -.
- beq, bne: 0 / 0 / none / -.
- jr: 0 / - / none / -.
- jal: - / - / 31 / 0.
- j: no sources, no dest.
- instr_d==0 and any unrecognised encoding: treated as nop, with no sources and no dest.
REQ-013 SHALL hold a scoreboard of STAGES entries, each {dest[4:0], tnew[1:0]}, where entry k describes the instruction k stages past decode.
REQ-014 SHALL, on a clock edge with en=1 and reset=0, update the scoreboard as follows:
- entry k+1 <= entry k with tnew saturating-decremented (0 stays 0).
- entry 1 <= decoded instr_d when stall=0.
- entry 1 <= bubble {0,0} when stall=1.
- the oldest entry is discarded.
REQ-015 SHALL hold all scoreboard entries and stall_cnt unchanged when en=0; outputs remain combinational on the held state.
REQ-016 SHALL, for each used source register r != 0, select the match as the smallest k with entry k dest == r.
- Only this nearest match is considered.
- Entries with dest 0 never match.
REQ-017 SHALL assert stall when any used source has a match whose tnew > that source's Tuse; stall is combinational in the same cycle.
REQ-018 SHALL set fwd_X_sel = k when the match exists and has tnew == 0, and 0 otherwise (no match, unused source, r == 0, or tnew > 0).
REQ-019 SHALL drive fwd_rs_sel and fwd_rt_sel independently; both may select the same stage.
REQ-020 SHALL increment stall_cnt by 1 on each edge with en=1, stall=1, reset=0; it wraps from 0xFFFFFFFF to 0.
REQ-021 SHALL, when an instruction both reads and writes the same register (e.g. addu $1,$1,$2), compute the hazard only against older entries and never against itself.

Reset
REQ-022 SHALL, on an edge with reset=1 (regardless of en), set every scoreboard entry to {0,0} and stall_cnt to 0.
REQ-023 SHALL, in the cycle after reset, drive stall=0 and fwd_rs_sel=fwd_rt_sel=0 for any instr_d.
REQ-024 SHALL let reset asserted mid-stall discard the pending hazard with no residual stall.

Verification
REQ-025 SHALL cover: lw $1,0($2) then addu $3,$1,$4, en=1.
- Response: stall=1 for exactly one cycle.
- Next cycle (lw at M, tnew 1): stall=0, fwd_rs_sel=0.
- stall_cnt=1.
REQ-026 SHALL cover: addu $5,$6,$7 then beq $5,$0.
- Response: stall=1 one cycle (E tnew 1 > Tuse 0).
- Next cycle: stall=0, fwd_rs_sel=2, fwd_rt_sel=0.
REQ-027 SHALL cover: jal then jr $31 -> stall=0, fwd_rs_sel=1 in the cycle jr is in decode.
REQ-028 SHALL cover: lui $0,... then addu $3,$0,$0 -> stall=0, both selects 0.
REQ-029 SHALL cover: ori $1 followed by lw $1 in flight, then beq $1,$1.
- Response: nearest match (lw, tnew 2) governs; stall=1 two cycles; stall_cnt=2.
REQ-030 SHALL cover: reset=1 during a lw-use stall, and en=0 for 3 cycles during a stall.
- After reset: stall=0 and stall_cnt=0 next cycle.
- With en=0: scoreboard frozen, stall held at 1, stall_cnt unchanged.
